// File: rtl/counter_bank.sv
// Bank of independent event counters sharing one enable and one load port.
// Each channel wraps or saturates and reports terminal count as pulse, toggle and sat level.
module counter_bank #(
   parameter  int WIDTH    = 8,
   parameter  int CHANNELS = 4,
   parameter  int SATURATE = 0,
   localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      enable_i,
   input  logic [CHANNELS-1:0]       inc_i,
   input  logic [CHANNELS-1:0]       clr_i,
   input  logic                      load_i,
   input  logic [SEL_W-1:0]          load_sel_i,
   input  logic [WIDTH-1:0]          data_i,
   output logic [CHANNELS*WIDTH-1:0] count_o,
   output logic [CHANNELS-1:0]       wrap_o,
   output logic [CHANNELS-1:0]       toggle_o,
   output logic [CHANNELS-1:0]       sat_o
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0]    count_q [CHANNELS];
   logic [WIDTH-1:0]    count_d [CHANNELS];
   logic [CHANNELS-1:0] wrap_q, wrap_d;
   logic [CHANNELS-1:0] toggle_q, toggle_d;
   logic [CHANNELS-1:0] sat_q, sat_d;

   always_comb begin
      wrap_d   = '0;
      toggle_d = toggle_q;
      sat_d    = sat_q;
      for (int n = 0; n < CHANNELS; n++) begin
         count_d[n] = count_q[n];
         if (clr_i[n]) begin
            count_d[n] = '0;
            sat_d[n]   = 1'b0;
         end else if (enable_i && load_i && (load_sel_i == SEL_W'(n))) begin
            // Out-of-range selects never match any channel, so they fall through harmlessly.
            count_d[n] = data_i;
            sat_d[n]   = (SATURATE != 0) && (data_i == CNT_MAX);
         end else if (enable_i && inc_i[n]) begin
            if (SATURATE != 0) begin
               if (count_q[n] != CNT_MAX) begin
                  count_d[n] = count_q[n] + 1'b1;
                  if (count_q[n] == CNT_MAX - WIDTH'(1)) begin
                     wrap_d[n]   = 1'b1;
                     toggle_d[n] = ~toggle_q[n];
                     sat_d[n]    = 1'b1;
                  end
               end
            end else begin
               count_d[n] = count_q[n] + 1'b1;
               if (count_q[n] == CNT_MAX) begin
                  wrap_d[n]   = 1'b1;
                  toggle_d[n] = ~toggle_q[n];
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int n = 0; n < CHANNELS; n++) count_q[n] <= '0;
         wrap_q   <= '0;
         toggle_q <= '0;
         sat_q    <= '0;
      end else begin
         for (int n = 0; n < CHANNELS; n++) count_q[n] <= count_d[n];
         wrap_q   <= wrap_d;
         toggle_q <= toggle_d;
         sat_q    <= sat_d;
      end
   end

   always_comb begin
      count_o = '0;
      for (int n = 0; n < CHANNELS; n++) count_o[n*WIDTH +: WIDTH] = count_q[n];
   end

   assign wrap_o   = wrap_q;
   assign toggle_o = toggle_q;
   assign sat_o    = sat_q;

endmodule

// File: tb/tb_counter_bank.sv
// Bench for counter_bank: four parameterisations driven from one shared stimulus,
// checked every cycle against an arithmetic model plus literal expectations.
module tb_counter_bank;

   localparam int ND = 4;
   localparam int MW  [ND] = '{4, 4, 8, 1};
   localparam int MCH [ND] = '{4, 3, 3, 2};
   localparam int MSAT[ND] = '{0, 1, 0, 0};
   localparam int MSW [ND] = '{2, 2, 2, 1};

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en  = 1'b0;
   logic [3:0] inc = '0;
   logic [3:0] clr = '0;
   logic       load = 1'b0;
   logic [1:0] sel  = '0;
   logic [7:0] data = '0;

   logic [15:0] c0; logic [3:0] w0, t0, s0;
   logic [11:0] c1; logic [2:0] w1, t1, s1;
   logic [23:0] c2; logic [2:0] w2, t2, s2;
   logic [1:0]  c3; logic [1:0] w3, t3, s3;

   int checks = 0;
   int errors = 0;
   int wrap1_pulses = 0;

   int mcnt [ND][4];
   int mtog [ND][4];
   int msat [ND][4];
   int mwrap[ND][4];

   always #5 clk = ~clk;

   counter_bank #(.WIDTH(4), .CHANNELS(4), .SATURATE(0)) u_d0 (
      .clk_i(clk), .rst_i(rst), .enable_i(en), .inc_i(inc), .clr_i(clr),
      .load_i(load), .load_sel_i(sel), .data_i(data[3:0]),
      .count_o(c0), .wrap_o(w0), .toggle_o(t0), .sat_o(s0));

   counter_bank #(.WIDTH(4), .CHANNELS(3), .SATURATE(1)) u_d1 (
      .clk_i(clk), .rst_i(rst), .enable_i(en), .inc_i(inc[2:0]), .clr_i(clr[2:0]),
      .load_i(load), .load_sel_i(sel), .data_i(data[3:0]),
      .count_o(c1), .wrap_o(w1), .toggle_o(t1), .sat_o(s1));

   counter_bank #(.WIDTH(8), .CHANNELS(3), .SATURATE(0)) u_d2 (
      .clk_i(clk), .rst_i(rst), .enable_i(en), .inc_i(inc[2:0]), .clr_i(clr[2:0]),
      .load_i(load), .load_sel_i(sel), .data_i(data),
      .count_o(c2), .wrap_o(w2), .toggle_o(t2), .sat_o(s2));

   counter_bank #(.WIDTH(1), .CHANNELS(2), .SATURATE(0)) u_d3 (
      .clk_i(clk), .rst_i(rst), .enable_i(en), .inc_i(inc[1:0]), .clr_i(clr[1:0]),
      .load_i(load), .load_sel_i(sel[0]), .data_i(data[0]),
      .count_o(c3), .wrap_o(w3), .toggle_o(t3), .sat_o(s3));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: one increment/clear/load step per channel, written from the counting rules.
   function automatic void mstep(input int d, input int n,
                                 output int c, output int t, output int s, output int w);
      int mx;
      int selv;
      mx   = (1 << MW[d]) - 1;
      selv = int'(sel) % (1 << MSW[d]);
      c = mcnt[d][n]; t = mtog[d][n]; s = msat[d][n]; w = 0;
      if (clr[n]) begin
         c = 0; s = 0;
      end else if (en && load && selv == n) begin
         c = int'(data) & mx;
         s = (MSAT[d] != 0 && c == mx) ? 1 : 0;
      end else if (en && inc[n]) begin
         if (c == mx) begin
            if (MSAT[d] == 0) begin
               c = 0; w = 1; t = 1 - t;
            end
         end else begin
            c = c + 1;
            if (MSAT[d] != 0 && c == mx) begin
               w = 1; t = 1 - t; s = 1;
            end
         end
      end
   endfunction

   always @(posedge clk or negedge rst) begin
      int c, t, s, w;
      if (!rst) begin
         for (int d = 0; d < ND; d++)
            for (int n = 0; n < 4; n++) begin
               mcnt[d][n] <= 0; mtog[d][n] <= 0; msat[d][n] <= 0; mwrap[d][n] <= 0;
            end
      end else begin
         for (int d = 0; d < ND; d++)
            for (int n = 0; n < MCH[d]; n++) begin
               mstep(d, n, c, t, s, w);
               mcnt[d][n] <= c; mtog[d][n] <= t; msat[d][n] <= s; mwrap[d][n] <= w;
            end
      end
   end

   function automatic void get_act(input int d, input int n,
                                   output int c, output int w, output int t, output int s);
      case (d)
         0:       begin c = int'(c0[n*4 +: 4]); w = int'(w0[n]); t = int'(t0[n]); s = int'(s0[n]); end
         1:       begin c = int'(c1[n*4 +: 4]); w = int'(w1[n]); t = int'(t1[n]); s = int'(s1[n]); end
         2:       begin c = int'(c2[n*8 +: 8]); w = int'(w2[n]); t = int'(t2[n]); s = int'(s2[n]); end
         default: begin c = int'(c3[n]);        w = int'(w3[n]); t = int'(t3[n]); s = int'(s3[n]); end
      endcase
   endfunction

   always @(negedge clk) begin
      int c, w, t, s;
      if (rst) begin
         for (int d = 0; d < ND; d++)
            for (int n = 0; n < MCH[d]; n++) begin
               get_act(d, n, c, w, t, s);
               chk($sformatf("model_count d%0d ch%0d", d, n), c, mcnt[d][n]);
               chk($sformatf("model_wrap d%0d ch%0d", d, n), w, mwrap[d][n]);
               chk($sformatf("model_toggle d%0d ch%0d", d, n), t, mtog[d][n]);
               chk($sformatf("model_sat d%0d ch%0d", d, n), s, msat[d][n]);
            end
         if (w1[0]) wrap1_pulses++;
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   logic [19:0] vec [8] = '{
      20'b1_1111_0000_0_00_00000000,
      20'b1_0101_1010_1_01_11111111,
      20'b1_1010_0000_1_10_11111110,
      20'b1_1111_0000_0_00_00000000,
      20'b0_1111_0001_1_00_00001111,
      20'b1_0110_0000_1_11_00001110,
      20'b1_1111_1111_0_00_00000000,
      20'b1_1001_0000_0_00_00000000
   };

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_count0", 32'(c0), 32'h0);
      chk("reset_wrap0", 32'(w0), 32'h0);
      chk("reset_toggle0", 32'(t0), 32'h0);
      chk("reset_sat1", 32'(s1), 32'h0);
      rst = 1'b1;
      tick();

      en = 1'b1; inc = 4'b0001;
      repeat (16) tick();
      chk("wrap_count_ch0", 32'(c0[3:0]), 32'h0);
      chk("wrap_pulse_ch0", 32'(w0[0]), 32'h1);
      chk("wrap_toggle_ch0", 32'(t0[0]), 32'h1);
      chk("w8_count_ch0", 32'(c2[7:0]), 32'h10);
      chk("w1_toggle_ch0", 32'(t3[0]), 32'h0);

      repeat (4) tick();
      chk("sat_count_ch0", 32'(c1[3:0]), 32'hF);
      chk("sat_flag_ch0", 32'(s1[0]), 32'h1);
      chk("sat_single_pulse", 32'(wrap1_pulses), 32'h1);
      chk("wrap_count_after20", 32'(c0[3:0]), 32'h4);

      inc = '0; clr = 4'b0001;
      tick();
      chk("sat_clr_count", 32'(c1[3:0]), 32'h0);
      chk("sat_clr_flag", 32'(s1[0]), 32'h0);
      chk("sat_clr_toggle_kept", 32'(t1[0]), 32'h1);

      clr = 4'b0100; load = 1'b1; sel = 2'd2; data = 8'hA5; inc = 4'b0100;
      tick();
      chk("prio_clr", 32'(c2[23:16]), 32'h0);
      clr = '0;
      tick();
      chk("prio_load", 32'(c2[23:16]), 32'hA5);
      load = 1'b0;
      tick();
      chk("prio_inc", 32'(c2[23:16]), 32'hA6);

      en = 1'b0; inc = 4'hF; load = 1'b1; sel = 2'd0; data = 8'h33;
      tick();
      chk("en_gate_ch2", 32'(c2[23:16]), 32'hA6);
      clr = 4'b0010;
      tick();
      chk("en_gate_clr_ch1", 32'(c2[15:8]), 32'h0);
      chk("en_gate_ch2_again", 32'(c2[23:16]), 32'hA6);

      clr = '0; en = 1'b1; sel = 2'd3; data = 8'h7F; inc = 4'b0111;
      tick();
      chk("oor_load_all", 32'(c2), 32'hA70101);
      chk("w1_ch1_after_oor", 32'(c3[1]), 32'h1);

      load = 1'b0; inc = 4'b0010;
      tick();
      chk("w1_wrap_count", 32'(c3[1]), 32'h0);
      chk("w1_wrap_pulse", 32'(w3[1]), 32'h1);
      chk("w1_wrap_toggle", 32'(t3[1]), 32'h1);
      tick();
      chk("w1_no_pulse", 32'(w3[1]), 32'h0);
      chk("w1_count_back", 32'(c3[1]), 32'h1);

      for (int i = 0; i < 8; i++) begin
         {en, inc, clr, load, sel, data} = vec[i];
         tick();
      end

      en = 1'b1; inc = 4'hF; clr = '0; load = 1'b0;
      repeat (3) tick();
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async_reset_count0", 32'(c0), 32'h0);
      chk("async_reset_count2", 32'(c2), 32'h0);
      chk("async_reset_wrap_toggle", 32'({w0, t0, t2}), 32'h0);
      chk("async_reset_sat1", 32'(s1), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) tick();
      chk("post_reset_count0", 32'(c0[3:0]), 32'h3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
